// File: rtl/mem_port_sequencer.sv
// Per-port request sequencer in front of one port of the dual-port memory.
// Client requests are queued in a small circular FIFO, issued one at a time
// on the memory valid/ready handshake, and answered in order with exactly one
// response per request (read data or a write acknowledge).
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | nothing outstanding; pop the FIFO head as soon as one exists
// ST_ISSUE   | mem_valid held with stable mem_* fields until mem_ready
// ST_WAIT_RD | read accepted; capture mem_rd_data this cycle
// ST_RESP    | rsp_valid held with stable rsp_* fields until rsp_ready
module mem_port_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic                     mem_op,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wr_data,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_we,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_RESP
    } state_t;

    state_t state;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;
    logic [PTR_W:0]      occupancy;
    logic                out_of_reset;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [PTR_W-1:0]    head_idx;

    logic                fifo_we    [DEPTH];
    logic [ADDR_W-1:0]   fifo_addr  [DEPTH];
    logic [DATA_W-1:0]   fifo_wdata [DEPTH];

    assign occupancy  = wr_ptr - rd_ptr;
    assign fifo_count = occupancy;
    assign fifo_full  = (occupancy == FULL_COUNT);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign head_idx   = rd_ptr[PTR_W-1:0];

    // out_of_reset keeps req_ready low while rst is held, using only flops.
    assign req_ready = out_of_reset && !fifo_full;
    assign push      = req_valid && req_ready;
    assign pop       = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));

    // Pointer and reset-status bookkeeping for the request FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr[PTR_W-1:0]]    <= req_we;
            fifo_addr[wr_ptr[PTR_W-1:0]]  <= req_addr;
            fifo_wdata[wr_ptr[PTR_W-1:0]] <= req_wdata;
        end
    end

    // Issue/response sequencing with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem_valid   <= 1'b0;
            mem_op      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            rsp_valid   <= 1'b0;
            rsp_we      <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        mem_valid   <= 1'b1;
                        mem_op      <= fifo_we[head_idx];
                        mem_addr    <= fifo_addr[head_idx];
                        mem_wr_data <= fifo_wdata[head_idx];
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (mem_op) begin
                            // Writes need no data back, so acknowledge at once.
                            rsp_valid <= 1'b1;
                            rsp_we    <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= ST_RESP;
                        end else begin
                            state <= ST_WAIT_RD;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    rsp_valid <= 1'b1;
                    rsp_we    <= 1'b0;
                    rsp_rdata <= mem_rd_data;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (!fifo_empty) begin
                            mem_valid   <= 1'b1;
                            mem_op      <= fifo_we[head_idx];
                            mem_addr    <= fifo_addr[head_idx];
                            mem_wr_data <= fifo_wdata[head_idx];
                            state       <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed testbench for mem_port_sequencer with a behavioural memory port.
module tb_mem_port_sequencer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic [2:0]        fifo_count;

    mem_port_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_we     (rsp_we),
        .rsp_rdata  (rsp_rdata),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory port model plus handshake monitors.
    logic [DATA_W-1:0] mem_model [256];
    int                mem_acc_cnt = 0;
    int                max_cnt     = 0;
    logic [32:0]       rsp_q [$];

    always @(posedge clk) begin
        if (mem_valid && mem_ready) begin
            mem_acc_cnt++;
            if (mem_op) mem_model[mem_addr] <= mem_wr_data;
            else        mem_rd_data <= mem_model[mem_addr];
        end
        if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_we, rsp_rdata});
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_one(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            cyc();
            n++;
        end
        if (!req_ready) check("push_timeout", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp_total(input string tag, input int n);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < 1000) begin
            cyc();
            k++;
        end
        check(tag, rsp_q.size(), n);
    endtask

    int          base;
    int          acc0;
    int          exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
    logic [31:0] d5 [20];
    logic [32:0] exp5 [20];
    logic [32:0] exp_rsp;
    logic [31:0] val;
    bit          stream_done;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        cyc();
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        rst = 1'b0;
        cyc();
        check("ready_after_rst", req_ready, 1);

        // Test 1: single write then read with exact latencies.
        mem_ready = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05; req_wdata = 32'hDEADBEEF;
        cyc();
        req_valid = 1'b0;
        check("t1_cnt_after_push", fifo_count, 1);
        check("t1_no_issue_yet", mem_valid, 0);
        cyc();
        check("t1_wr_mem_valid", mem_valid, 1);
        check("t1_wr_mem_op", mem_op, 1);
        check("t1_wr_mem_addr", mem_addr, 8'h05);
        check("t1_wr_mem_data", mem_wr_data, 32'hDEADBEEF);
        cyc();
        check("t1_wack_valid", rsp_valid, 1);
        check("t1_wack_we", rsp_we, 1);
        check("t1_wack_rdata", rsp_rdata, 0);
        check("t1_wack_mem_valid", mem_valid, 0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05; req_wdata = '0;
        cyc();
        req_valid = 1'b0;
        check("t1_wack_taken", rsp_valid, 0);
        check("t1_rd_queued", fifo_count, 1);
        cyc();
        check("t1_rd_mem_valid", mem_valid, 1);
        check("t1_rd_mem_op", mem_op, 0);
        cyc();
        check("t1_wait_rd_no_rsp", rsp_valid, 0);
        cyc();
        check("t1_rd_rsp_valid", rsp_valid, 1);
        check("t1_rd_rsp_we", rsp_we, 0);
        check("t1_rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        cyc();
        check("t1_rd_rsp_taken", rsp_valid, 0);

        // Test 2: fill the FIFO while the memory stalls.
        mem_ready = 1'b0; rsp_ready = 1'b1;
        base = rsp_q.size();
        acc0 = mem_acc_cnt;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_we = 1'b1;
            req_addr = 8'h10 + 8'(i); req_wdata = 32'hA0 + 32'(i);
            cyc();
            check("t2_fifo_count", fifo_count, exp_cnt[i]);
            if (i >= 1) check("t2_mem_addr_stable", mem_addr, 8'h10);
            if (i >= 4) check("t2_req_ready_full", req_ready, 0);
        end
        req_valid = 1'b0;
        mem_ready = 1'b1;
        wait_rsp_total("t2_drain", base + 5);
        repeat (10) cyc();
        check("t2_no_extra_rsp", rsp_q.size(), base + 5);
        check("t2_accepts", mem_acc_cnt - acc0, 5);
        check("t2_last_addr", mem_addr, 8'h14);

        // Test 3: memory back-pressure for 7 cycles.
        mem_ready = 1'b0;
        base = rsp_q.size();
        acc0 = mem_acc_cnt;
        push_one(1'b1, 8'h33, 32'h12345678);
        cyc();
        for (int i = 0; i < 7; i++) begin
            check("t3_mem_valid", mem_valid, 1);
            check("t3_mem_op", mem_op, 1);
            check("t3_mem_addr", mem_addr, 8'h33);
            check("t3_mem_data", mem_wr_data, 32'h12345678);
            cyc();
        end
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        check("t3_wack_next_edge", rsp_valid, 1);
        repeat (5) cyc();
        check("t3_one_accept", mem_acc_cnt - acc0, 1);
        check("t3_one_rsp", rsp_q.size() - base, 1);

        // Test 4: response back-pressure with three queued reads.
        mem_ready = 1'b1; rsp_ready = 1'b1;
        base = rsp_q.size();
        push_one(1'b1, 8'h01, 32'h11);
        push_one(1'b1, 8'h02, 32'h22);
        push_one(1'b1, 8'h03, 32'h33);
        wait_rsp_total("t4_preload", base + 3);
        rsp_ready = 1'b0;
        base = rsp_q.size();
        push_one(1'b0, 8'h01, '0);
        push_one(1'b0, 8'h02, '0);
        push_one(1'b0, 8'h03, '0);
        for (int k = 0; k < 50 && !rsp_valid; k++) cyc();
        acc0 = mem_acc_cnt;
        for (int i = 0; i < 10; i++) begin
            check("t4_no_issue", mem_valid, 0);
            check("t4_rsp_held", rsp_valid, 1);
            check("t4_rsp_data_held", rsp_rdata, 32'h11);
            cyc();
        end
        check("t4_no_mem_accepts", mem_acc_cnt - acc0, 0);
        check("t4_queued", fifo_count, 2);
        rsp_ready = 1'b1;
        wait_rsp_total("t4_drain", base + 3);
        for (int k = 0; k < 3; k++) begin
            val = 32'h11 * 32'(k + 1);
            exp_rsp = {1'b0, val};
            if (rsp_q.size() > base + k) check("t4_rsp_order", rsp_q[base + k], exp_rsp);
        end

        // Test 5: alternating write/read stream with random stalls.
        for (int i = 0; i < 20; i++) begin
            d5[i] = $urandom;
            if (i % 2 == 0) exp5[i] = {1'b1, 32'h0};
            else            exp5[i] = {1'b0, d5[i-1]};
        end
        base = rsp_q.size();
        max_cnt = 0;
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push_one((i % 2) == 0, 8'(i / 2), d5[i]);
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    rsp_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
        join
        mem_ready = 1'b1; rsp_ready = 1'b1;
        wait_rsp_total("t5_drain", base + 20);
        repeat (10) cyc();
        check("t5_no_dup", rsp_q.size(), base + 20);
        for (int i = 0; i < 20; i++) begin
            if (rsp_q.size() > base + i) check("t5_rsp", rsp_q[base + i], exp5[i]);
        end
        check("t5_max_cnt_ok", max_cnt <= DEPTH, 1);

        // Test 6: reset while in WAIT_RD with two requests queued.
        mem_ready = 1'b0; rsp_ready = 1'b1;
        push_one(1'b0, 8'h00, '0);
        push_one(1'b0, 8'h01, '0);
        push_one(1'b0, 8'h02, '0);
        check("t6_queued", fifo_count, 2);
        check("t6_issuing", mem_valid, 1);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        check("t6_in_wait_rd", rsp_valid, 0);
        check("t6_wait_mem_valid", mem_valid, 0);
        base = rsp_q.size();
        acc0 = mem_acc_cnt;
        rst = 1'b1;
        cyc();
        check("t6_rst_mem_valid", mem_valid, 0);
        check("t6_rst_rsp_valid", rsp_valid, 0);
        check("t6_rst_fifo_count", fifo_count, 0);
        check("t6_rst_req_ready", req_ready, 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        repeat (10) cyc();
        check("t6_no_discarded_rsp", rsp_q.size(), base);
        check("t6_no_discarded_issue", mem_acc_cnt - acc0, 0);
        check("t6_ready_again", req_ready, 1);
        push_one(1'b1, 8'h40, 32'hCAFEF00D);
        push_one(1'b0, 8'h40, '0);
        wait_rsp_total("t6_resume", base + 2);
        if (rsp_q.size() >= base + 2) begin
            check("t6_resume_wack", rsp_q[base], {1'b1, 32'h0});
            check("t6_resume_rd", rsp_q[base + 1], {1'b0, 32'hCAFEF00D});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
